// File: rtl/dac_mode_sequencer.sv
`default_nettype none
// ============================================================================
// dac_mode_sequencer: debounces MCU mode pins and steps DAC/PLL through
// mute -> reset -> reconfigure -> settle -> release -> unmute.
// Rev 1.0
// ============================================================================
module dac_mode_sequencer #(
  parameter int STABLE_CYCLES = 4096,
  parameter int MUTE_WAIT     = 24000,
  parameter int RST_HOLD      = 240,
  parameter int PLL_SETTLE    = 48000,
  parameter int UNMUTE_WAIT   = 24000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mcu_44_48,
  input  logic [1:0] mcu_f,
  input  logic       mcu_dsd_on,
  input  logic       mcu_mute,
  input  logic       mcu_dac_reset,
  output logic       dac_44_48,
  output logic [1:0] dac_f,
  output logic       dac_dsd,
  output logic       dac_mute,
  output logic       dac_reset,
  output logic [1:0] pll_s,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUTE   = 3'd1,
    S_RST    = 3'd2,
    S_SETTLE = 3'd3,
    S_RUNW   = 3'd4
  } state_t;

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] MUTE_LOAD   = 16'(MUTE_WAIT - 1);
  localparam logic [15:0] RST_LOAD    = 16'(RST_HOLD - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(PLL_SETTLE - 1);
  localparam logic [15:0] RUNW_LOAD   = 16'(UNMUTE_WAIT - 1);
  localparam logic [3:0]  CFG_RESET   = 4'b0001;

  // cfg bit order: {44_48, f[1:0], dsd_on}
  logic [3:0]  cfg_s1, cfg_s2, cfg_prev;
  logic        mute_s1, mute_s2, drst_s1, drst_s2;
  logic [15:0] stable_cnt;
  logic [3:0]  tgt, tgt_prev, applied;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        seq_mute, seq_reset, load_applied;
  logic        retarget;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_s1     <= CFG_RESET;
      cfg_s2     <= CFG_RESET;
      mute_s1    <= 1'b0;
      mute_s2    <= 1'b0;
      drst_s1    <= 1'b0;
      drst_s2    <= 1'b0;
      cfg_prev   <= CFG_RESET;
      stable_cnt <= '0;
      tgt        <= CFG_RESET;
      tgt_prev   <= CFG_RESET;
    end else begin
      cfg_s1   <= {mcu_44_48, mcu_f, mcu_dsd_on};
      cfg_s2   <= cfg_s1;
      mute_s1  <= mcu_mute;
      mute_s2  <= mute_s1;
      drst_s1  <= mcu_dac_reset;
      drst_s2  <= drst_s1;
      cfg_prev <= cfg_s2;
      tgt_prev <= tgt;
      // Counter saturates once the value is accepted; reloading tgt is harmless.
      if (cfg_s2 != cfg_prev) begin
        stable_cnt <= '0;
      end else if (stable_cnt == STABLE_LAST) begin
        tgt <= cfg_s2;
      end else begin
        stable_cnt <= stable_cnt + 16'd1;
      end
    end
  end

  // A fresh target differing from what is applied restarts the reset phase.
  assign retarget = (tgt != tgt_prev) && (tgt != applied);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    seq_mute     = 1'b1;
    seq_reset    = 1'b0;
    load_applied = 1'b0;
    case (state)
      S_IDLE: begin
        seq_mute = 1'b0;
        if (tgt != applied) begin
          state_nxt = S_MUTE;
          cnt_nxt   = MUTE_LOAD;
        end
      end
      S_MUTE: begin
        if (cnt == '0) begin
          state_nxt = S_RST;
          cnt_nxt   = RST_LOAD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      S_RST: begin
        seq_reset = 1'b1;
        if (retarget) begin
          cnt_nxt = RST_LOAD;
        end else if (cnt == '0) begin
          state_nxt    = S_SETTLE;
          cnt_nxt      = SETTLE_LOAD;
          load_applied = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      S_SETTLE: begin
        seq_reset = 1'b1;
        if (retarget) begin
          state_nxt = S_RST;
          cnt_nxt   = RST_LOAD;
        end else if (cnt == '0) begin
          state_nxt = S_RUNW;
          cnt_nxt   = RUNW_LOAD;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      S_RUNW: begin
        if (retarget) begin
          state_nxt = S_RST;
          cnt_nxt   = RST_LOAD;
        end else if (cnt == '0) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: begin
        state_nxt = S_RST;
        cnt_nxt   = RST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RST;
      cnt       <= RST_LOAD;
      applied   <= CFG_RESET;
      dac_44_48 <= 1'b0;
      dac_f     <= 2'b00;
      dac_dsd   <= 1'b1;
      pll_s     <= 2'b10;
      dac_mute  <= 1'b1;
      dac_reset <= 1'b1;
      busy      <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_applied) begin
        applied <= tgt;
      end
      dac_44_48 <= applied[3];
      dac_f     <= applied[2:1];
      dac_dsd   <= applied[0];
      pll_s     <= {applied[0], applied[3]};
      dac_mute  <= seq_mute | mute_s2;
      dac_reset <= seq_reset | drst_s2;
      busy      <= (state != S_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_mode_sequencer.sv
`default_nettype none
// Directed bench for dac_mode_sequencer with short timing parameters.
// Cycle index k below is the first clock edge that samples a new pin value.
module tb_dac_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mcu_44_48 = 1'b0;
  logic [1:0] mcu_f = 2'b00;
  logic       mcu_dsd_on = 1'b1;
  logic       mcu_mute = 1'b0;
  logic       mcu_dac_reset = 1'b0;
  logic       dac_44_48, dac_dsd, dac_mute, dac_reset, busy;
  logic [1:0] dac_f, pll_s;

  int checks = 0;
  int failures = 0;

  dac_mode_sequencer #(
    .STABLE_CYCLES(4), .MUTE_WAIT(8), .RST_HOLD(4), .PLL_SETTLE(16), .UNMUTE_WAIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .mcu_44_48(mcu_44_48), .mcu_f(mcu_f), .mcu_dsd_on(mcu_dsd_on),
    .mcu_mute(mcu_mute), .mcu_dac_reset(mcu_dac_reset),
    .dac_44_48(dac_44_48), .dac_f(dac_f), .dac_dsd(dac_dsd),
    .dac_mute(dac_mute), .dac_reset(dac_reset), .pll_s(pll_s), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic a, input logic [1:0] f, input logic d);
    mcu_44_48  = a;
    mcu_f      = f;
    mcu_dsd_on = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_pins(1'b0, 2'b00, 1'b1);
    repeat (3) tick();
    checks++; if (dac_44_48 !== 1'b0) begin failures++; $display("FAIL reset_dac_44_48 got=%b exp=0", dac_44_48); end
    checks++; if (dac_f !== 2'b00) begin failures++; $display("FAIL reset_dac_f got=%b exp=00", dac_f); end
    checks++; if (dac_dsd !== 1'b1) begin failures++; $display("FAIL reset_dac_dsd got=%b exp=1", dac_dsd); end
    checks++; if (pll_s !== 2'b10) begin failures++; $display("FAIL reset_pll_s got=%b exp=10", pll_s); end
    checks++; if (dac_mute !== 1'b1) begin failures++; $display("FAIL reset_dac_mute got=%b exp=1", dac_mute); end
    checks++; if (dac_reset !== 1'b1) begin failures++; $display("FAIL reset_dac_reset got=%b exp=1", dac_reset); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
  endtask

  // Expects reset to be released just before the first edge of the loop.
  task automatic test_powerup(input string tag);
    logic er, em;
    reset = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      er = (i <= 20);
      em = (i <= 28);
      checks++; if (dac_reset !== er) begin failures++; $display("FAIL %s_dac_reset i=%0d got=%b exp=%b", tag, i, dac_reset, er); end
      checks++; if (dac_mute !== em) begin failures++; $display("FAIL %s_dac_mute i=%0d got=%b exp=%b", tag, i, dac_mute, em); end
      checks++; if (busy !== em) begin failures++; $display("FAIL %s_busy i=%0d got=%b exp=%b", tag, i, busy, em); end
      checks++; if (pll_s !== 2'b10) begin failures++; $display("FAIL %s_pll_s i=%0d got=%b exp=10", tag, i, pll_s); end
      checks++; if (dac_f !== 2'b00) begin failures++; $display("FAIL %s_dac_f i=%0d got=%b exp=00", tag, i, dac_f); end
    end
  endtask

  task automatic test_mode_change();
    logic er, em;
    logic [1:0] ef, ep;
    set_pins(1'b1, 2'b10, 1'b1);
    for (int i = 0; i <= 50; i++) begin
      tick();
      em = (i >= 8) && (i < 44);
      er = (i >= 16) && (i < 36);
      ef = (i >= 20) ? 2'b10 : 2'b00;
      ep = (i >= 20) ? 2'b11 : 2'b10;
      checks++; if (dac_mute !== em) begin failures++; $display("FAIL mode_dac_mute i=%0d got=%b exp=%b", i, dac_mute, em); end
      checks++; if (busy !== em) begin failures++; $display("FAIL mode_busy i=%0d got=%b exp=%b", i, busy, em); end
      checks++; if (dac_reset !== er) begin failures++; $display("FAIL mode_dac_reset i=%0d got=%b exp=%b", i, dac_reset, er); end
      checks++; if (dac_f !== ef) begin failures++; $display("FAIL mode_dac_f i=%0d got=%b exp=%b", i, dac_f, ef); end
      checks++; if (pll_s !== ep) begin failures++; $display("FAIL mode_pll_s i=%0d got=%b exp=%b", i, pll_s, ep); end
    end
  endtask

  task automatic test_glitch();
    mcu_f = 2'b01;
    for (int i = 0; i <= 22; i++) begin
      tick();
      if (i == 2) mcu_f = 2'b10;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy i=%0d got=%b exp=0", i, busy); end
      checks++; if (dac_mute !== 1'b0) begin failures++; $display("FAIL glitch_dac_mute i=%0d got=%b exp=0", i, dac_mute); end
      checks++; if (dac_f !== 2'b10) begin failures++; $display("FAIL glitch_dac_f i=%0d got=%b exp=10", i, dac_f); end
    end
  endtask

  // dsd_on drops while in SETTLE: reset phase restarts, mute stays up throughout.
  task automatic test_retarget();
    logic er, em, ed;
    logic [1:0] ef, ep;
    set_pins(1'b0, 2'b01, 1'b1);
    for (int i = 0; i <= 62; i++) begin
      tick();
      if (i == 21) mcu_dsd_on = 1'b0;
      er = (i >= 16) && (i <= 49);
      em = (i >= 8) && (i <= 57);
      ed = (i < 34);
      ef = (i < 20) ? 2'b10 : 2'b01;
      ep = (i < 20) ? 2'b11 : ((i < 34) ? 2'b10 : 2'b00);
      checks++; if (dac_reset !== er) begin failures++; $display("FAIL retarget_dac_reset i=%0d got=%b exp=%b", i, dac_reset, er); end
      checks++; if (dac_mute !== em) begin failures++; $display("FAIL retarget_dac_mute i=%0d got=%b exp=%b", i, dac_mute, em); end
      checks++; if (dac_dsd !== ed) begin failures++; $display("FAIL retarget_dac_dsd i=%0d got=%b exp=%b", i, dac_dsd, ed); end
      checks++; if (dac_f !== ef) begin failures++; $display("FAIL retarget_dac_f i=%0d got=%b exp=%b", i, dac_f, ef); end
      checks++; if (pll_s !== ep) begin failures++; $display("FAIL retarget_pll_s i=%0d got=%b exp=%b", i, pll_s, ep); end
    end
  endtask

  task automatic test_override();
    logic er, em;
    logic [1:0] ep;
    mcu_mute = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      em = (i >= 3);
      checks++; if (dac_mute !== em) begin failures++; $display("FAIL ovr_mute_on i=%0d got=%b exp=%b", i, dac_mute, em); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovr_mute_busy i=%0d got=%b exp=0", i, busy); end
    end
    mcu_mute = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      em = (i < 3);
      checks++; if (dac_mute !== em) begin failures++; $display("FAIL ovr_mute_off i=%0d got=%b exp=%b", i, dac_mute, em); end
      checks++; if (dac_reset !== 1'b0) begin failures++; $display("FAIL ovr_mute_rst i=%0d got=%b exp=0", i, dac_reset); end
    end
    set_pins(1'b1, 2'b00, 1'b0);
    for (int i = 0; i <= 50; i++) begin
      tick();
      if (i == 36) mcu_dac_reset = 1'b1;
      if (i == 40) mcu_dac_reset = 1'b0;
      er = ((i >= 16) && (i <= 35)) || ((i >= 39) && (i <= 42));
      em = (i >= 8) && (i < 44);
      ep = (i >= 20) ? 2'b01 : 2'b00;
      checks++; if (dac_reset !== er) begin failures++; $display("FAIL ovr_rst i=%0d got=%b exp=%b", i, dac_reset, er); end
      checks++; if (dac_mute !== em) begin failures++; $display("FAIL ovr_rst_mute i=%0d got=%b exp=%b", i, dac_mute, em); end
      checks++; if (busy !== em) begin failures++; $display("FAIL ovr_rst_busy i=%0d got=%b exp=%b", i, busy, em); end
      checks++; if (pll_s !== ep) begin failures++; $display("FAIL ovr_rst_pll_s i=%0d got=%b exp=%b", i, pll_s, ep); end
    end
  endtask

  task automatic test_reset_mid();
    logic er;
    set_pins(1'b1, 2'b11, 1'b0);
    for (int i = 0; i <= 25; i++) begin
      tick();
      er = (i >= 16);
      checks++; if (dac_reset !== er) begin failures++; $display("FAIL rstmid_pre_rst i=%0d got=%b exp=%b", i, dac_reset, er); end
    end
    checks++; if (dac_f !== 2'b11) begin failures++; $display("FAIL rstmid_pre_dac_f got=%b exp=11", dac_f); end
    reset = 1'b1;
    set_pins(1'b0, 2'b00, 1'b1);
    tick();
    checks++; if (dac_44_48 !== 1'b0) begin failures++; $display("FAIL rstmid_dac_44_48 got=%b exp=0", dac_44_48); end
    checks++; if (dac_f !== 2'b00) begin failures++; $display("FAIL rstmid_dac_f got=%b exp=00", dac_f); end
    checks++; if (dac_dsd !== 1'b1) begin failures++; $display("FAIL rstmid_dac_dsd got=%b exp=1", dac_dsd); end
    checks++; if (pll_s !== 2'b10) begin failures++; $display("FAIL rstmid_pll_s got=%b exp=10", pll_s); end
    checks++; if (dac_mute !== 1'b1) begin failures++; $display("FAIL rstmid_dac_mute got=%b exp=1", dac_mute); end
    checks++; if (dac_reset !== 1'b1) begin failures++; $display("FAIL rstmid_dac_reset got=%b exp=1", dac_reset); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%b exp=1", busy); end
    test_powerup("rstmid_pwr");
  endtask

  initial begin
    test_reset();
    test_powerup("powerup");
    test_mode_change();
    test_glitch();
    test_retarget();
    test_override();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_mode_sequencer.md
Name: dac_mode_sequencer

Overview:
Sequences every DAC/PLL mode change requested by the MCU: sample family (44/48), rate (mcu_f) and format (DSD/PCM). The block synchronises and debounces the MCU control pins, then runs a fixed sequence: mute, hold DAC in reset, switch PLL/DAC config, wait for PLL settle, release reset, unmute. It sits in snos between the MCU control inputs and the dac_*/pll_s outputs, replacing the direct pass-through.

Parameters:
STABLE_CYCLES, 4096, consecutive clk cycles the synced config vector must be unchanged before acceptance (1..65535)
MUTE_WAIT, 24000, cycles muted before DAC reset asserts (1..65535)
RST_HOLD, 240, cycles DAC reset held before config outputs change (1..65535)
PLL_SETTLE, 48000, cycles after config change with reset still held (1..65535)
UNMUTE_WAIT, 24000, cycles after reset release before unmute (1..65535)

Ports:
clk  in  1  logic clock, 24 MHz
reset  in  1  synchronous, active-high
mcu_44_48  in  1  MCU family request: 0 = 44.1k, 1 = 48k (async)
mcu_f  in  2  MCU rate request (async)
mcu_dsd_on  in  1  MCU format: 0 = DSD, 1 = PCM (async)
mcu_mute  in  1  MCU mute request (async)
mcu_dac_reset  in  1  MCU DAC reset request (async)
dac_44_48  out  1  applied family
dac_f  out  2  applied rate
dac_dsd  out  1  applied format: 0 = DSD, 1 = PCM
dac_mute  out  1  DAC mute, 1 = muted
dac_reset  out  1  DAC reset, 1 = in reset
pll_s  out  2  PLL select = {dac_dsd, dac_44_48}
busy  out  1  1 while a sequence is in progress (state != IDLE)

Behaviour:
- All outputs are registered. Reset values: dac_44_48=0, dac_f=00, dac_dsd=1, pll_s=2'b10, dac_mute=1, dac_reset=1, busy=1.
- Sync: 2-FF synchroniser on each mcu_* input. Reset values of sync registers: 44_48=0, f=00, dsd_on=1, mute=0, dac_reset=0.
- Debounce: cfg = {44_48, f, dsd_on} (4 bits) after sync. A 16-bit counter clears whenever cfg differs from its value on the previous cycle. When the count reaches STABLE_CYCLES, cfg is copied into tgt. tgt reset value = 4'b0001.
- Detection latency: a pin change at edge k, held steady, updates tgt at edge k+2+STABLE_CYCLES.
- Seq mute and seq reset are internal bits. Outputs: dac_mute = seq_mute | mute_sync; dac_reset = seq_reset | dac_reset_sync.
- FSM states, with a single 16-bit down-counter. Each timed state lasts exactly its parameter in cycles.
  - IDLE: seq_mute=0, seq_reset=0. If tgt != applied, go to MUTE next cycle.
  - MUTE: seq_mute=1, seq_reset=0, MUTE_WAIT cycles, then RST.
  - RST: seq_mute=1, seq_reset=1, RST_HOLD cycles. On exit, applied <= tgt. dac_*/pll_s update on the first SETTLE cycle; go to SETTLE.
  - SETTLE: seq_mute=1, seq_reset=1, PLL_SETTLE cycles, then RUNW.
  - RUNW: seq_mute=1, seq_reset=0, UNMUTE_WAIT cycles, then IDLE.
- After reset the FSM starts in RST with applied=tgt=4'b0001, so the power-up sequence is RST→SETTLE→RUNW→IDLE.
- Retarget: if tgt changes while in RST, SETTLE or RUNW and differs from applied, go to RST next cycle with the counter reloaded. No re-mute is needed because seq_mute is already 1. A tgt change during MUTE needs no action, since tgt is sampled at RST exit.
- tgt changing back to equal applied while in MUTE: the sequence still completes (no abort).
- Outputs dac_44_48/dac_f/dac_dsd/pll_s never change while dac_reset=0.
- mcu_mute and mcu_dac_reset act in every state, with 3-cycle latency (sync + output register), and do not affect the FSM.
- Reset asserted mid-sequence forces the reset values on the next edge and restarts the power-up sequence.

Test Plan:
- Bench parameters for all scenarios: STABLE_CYCLES=4, MUTE_WAIT=8, RST_HOLD=4, PLL_SETTLE=16, UNMUTE_WAIT=8.
- Power-up: release reset with pins at {0,00,1}. Required: dac_reset=1 for 20 cycles, then 0. dac_mute=1 for 28 cycles, then 0. busy falls with dac_mute. pll_s stays 2'b10 throughout.
- Mode change: from IDLE, set mcu_44_48=1, mcu_f=10 at edge k. Required: tgt updates at k+6 and dac_mute=1 at k+8. dac_reset=1 from k+16 to k+36. dac_f=10 and pll_s=2'b11 at k+20. dac_mute=0 at k+44.
- Glitch rejection: toggle mcu_f for 3 cycles, then restore. Required: no tgt update, busy stays 0, dac_mute stays 0.
- Retarget: during SETTLE, change mcu_dsd_on 1→0. Required: RST re-entered with the counter reloaded. dac_dsd=0 and pll_s[1]=0 appear only while dac_reset=1. dac_mute stays 1 until the full RST+SETTLE+RUNW sequence completes.
- Override: assert mcu_mute in IDLE. Required: dac_mute=1 after 3 cycles, FSM stays in IDLE. Assert mcu_dac_reset during RUNW. Required: dac_reset=1 after 3 cycles, FSM timing unchanged.
- Reset mid-sequence: assert reset in SETTLE. Required: all outputs at their reset values on the next edge, then the power-up sequence runs again.
